sdram_mem_tester: RTL and testbench
===================================

Name: sdram_mem_tester

Overview:
- AXI-style master that drives the slave port of the team's SDRAM controller (aw/w/ar/r channels, no B channel).
- On a start pulse it writes an address-derived pattern over a configurable word range, then reads the range back and compares each word.
- Reports pass/fail, error count, first failing address/data, and a watchdog timeout.
- Used as the on-board SDRAM bring-up/self-test block on DE10-Lite, at 100 MHz in the controller's clk domain.

Parameters:
- ADDR_WIDTH, 25, address width; matches the controller's {bank, row, col} word address.
- DATA_WIDTH, 16, data word width.
- START_ADDR, 0, first word address tested.
- NUM_WORDS, 1024, number of words tested; must be >=1, and START_ADDR+NUM_WORDS-1 must be <= 2^ADDR_WIDTH-1.
- SEED, 16'hA5A5, pattern XOR seed.
- TIMEOUT, 1024, maximum cycles waiting for any single handshake; must be >=2.

Ports:
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-high
- start  in  1  begin test; sampled only in IDLE or DONE
- busy  out  1  test in progress
- done  out  1  test finished; sticky until next start
- pass  out  1  valid when done: error_count==0 and no timeout
- timeout  out  1  watchdog expired; sticky until next start
- error_count  out  16  read mismatches; saturates at 16'hFFFF
- first_err_addr  out  ADDR_WIDTH  address of first mismatch
- first_err_data  out  DATA_WIDTH  data read at first mismatch
- m_axi_awaddr  out  ADDR_WIDTH  write address
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  DATA_WIDTH  write data
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_araddr  out  ADDR_WIDTH  read address
- m_axi_arvalid  out  1
- m_axi_arready  in  1
- m_axi_rdata  in  DATA_WIDTH
- m_axi_rvalid  in  1
- m_axi_rready  out  1

Behaviour:
- Reset: every output is 0. State goes to IDLE, and all counters and captured registers clear. Reset is asynchronous, so it takes effect mid-transfer; valids drop in the same instant.
- Pattern: expected(a) = a[DATA_WIDTH-1:0] ^ SEED. Use the full address truncated to DATA_WIDTH.
- Registered state machine. All outputs come from registers or decode of the registered state; there is no combinational path from in to out.
- IDLE: busy=0.
  - start=1 -> WRITE; addr=START_ADDR, word_cnt=0.
  - Also clear error_count, first_err_*, timeout, done.
- WRITE: busy=1; awvalid=wvalid=1, awaddr=addr, wdata=expected(addr).
  - Handshake requires awvalid&awready&wvalid&wready in the same cycle. The controller only accepts paired aw+w.
  - Partial readiness (only one ready) is not a handshake. Both valids and the payload stay stable.
  - On handshake: if word_cnt==NUM_WORDS-1 -> READ_ADDR with addr=START_ADDR, word_cnt=0. Otherwise addr+1, word_cnt+1, and remain in WRITE.
  - Valids may stay high with the new payload the next cycle.
- READ_ADDR: arvalid=1, araddr=addr. On arvalid&arready -> READ_DATA, and arvalid goes low next cycle.
- READ_DATA: rready=1. On rvalid&rready, compare rdata with expected(addr).
  - On mismatch: error_count increments, saturating.
  - If this is the first mismatch (error_count was 0), capture first_err_addr=addr and first_err_data=rdata.
  - Then: last word -> DONE; otherwise addr+1, word_cnt+1 -> READ_ADDR.
  - Only one read is outstanding at a time.
- DONE: busy=0, done=1, pass=(error_count==0)&~timeout.
  - start=1 -> restart exactly as from IDLE. done and timeout clear the cycle the test restarts.
- Watchdog:
  - wd_cnt resets to 0 on every state change and on every handshake.
  - It increments while WRITE, READ_ADDR or READ_DATA waits.
  - When wd_cnt==TIMEOUT-1, the next cycle sets timeout=1, drops all valids/rready and goes to DONE.
  - This happens TIMEOUT cycles after the wait began.
- start while busy: ignored.
- start held high across DONE: restarts once on entering DONE+1. Start is level-sampled in DONE/IDLE only.
- word_cnt width: $clog2(NUM_WORDS+1). addr increment never wraps, per the parameter constraint.

Decomposition:
- Shared package sdram_pkg: ADDR_WIDTH/DATA_WIDTH defaults, the tester state encoding, and the expected-pattern function.
- One sub-module: sdram_tester_watchdog (counter, clear, enable, expire pulse, TIMEOUT param).
- The state machine, address counter and comparator stay in sdram_mem_tester.

Test Plan:
1. START_ADDR=0x10, NUM_WORDS=4, SEED=0xA5A5, ideal always-ready memory model -> writes 0x10:A5B5, 0x11:A5B4, 0x12:A5B7, 0x13:A5B6, then 4 reads; done=1, pass=1, error_count=0, timeout=0.
2. Same, but the model returns 0x0000 for 0x12 and 0xFFFF for 0x13 -> error_count=2, first_err_addr=0x12, first_err_data=0x0000, pass=0.
3. awready=1, wready=0 for 5 cycles, then both 1 -> no handshake, awaddr/wdata/valids stable for those 5 cycles; one write accepted on cycle 6; addr advances by exactly 1.
4. TIMEOUT=64, model never asserts arready -> timeout=1 exactly 64 cycles after arvalid rises; arvalid=0, done=1, pass=0.
5. Async reset asserted mid read pass (word 2 of 4) -> all outputs 0 immediately. After release, start runs the full 4-write/4-read sequence with pass=1.
6. start pulsed during WRITE -> no effect. start after DONE with errors present -> error_count, first_err_*, done cleared; rerun against the real sdram_controller gives pass=1.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM self-test master: default widths,
// tester state encoding and the address-derived test pattern.
package sdram_pkg;

    localparam int SDRAM_ADDR_WIDTH = 25;
    localparam int SDRAM_DATA_WIDTH = 16;
    localparam int PAT_W            = 64;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_READ_ADDR = 3'd2,
        ST_READ_DATA = 3'd3,
        ST_DONE      = 3'd4
    } tester_state_e;

    // Callers truncate the result to their data width, so only the low
    // address bits end up in the pattern.
    function automatic logic [PAT_W-1:0] sdram_pattern(input logic [PAT_W-1:0] addr,
                                                       input logic [PAT_W-1:0] seed);
        return addr ^ seed;
    endfunction

endpackage

// File: rtl/sdram_tester_watchdog.sv
// Handshake watchdog: counts wait cycles and pulses expire on the
// TIMEOUT-th consecutive cycle without progress.
module sdram_tester_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] wd_cnt_q;

    assign expire = enable && (wd_cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q <= '0;
        end else if (clear || expire) begin
            wd_cnt_q <= '0;
        end else if (enable) begin
            wd_cnt_q <= wd_cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/sdram_mem_tester.sv
// SDRAM bring-up master: writes an address-derived pattern over a word range,
// reads it back one word at a time and reports mismatches and timeouts.
module sdram_mem_tester
    import sdram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = SDRAM_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = SDRAM_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
    parameter int                    NUM_WORDS  = 1024,
    parameter logic [DATA_WIDTH-1:0] SEED       = 16'hA5A5,
    parameter int                    TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [15:0]           error_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] first_err_data,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int             WCW      = $clog2(NUM_WORDS + 1);
    localparam logic [WCW-1:0] LAST_CNT = WCW'(NUM_WORDS - 1);

    tester_state_e         state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WCW-1:0]        word_cnt_q;
    logic [15:0]           err_cnt_q;
    logic [ADDR_WIDTH-1:0] ferr_addr_q;
    logic [DATA_WIDTH-1:0] ferr_data_q;
    logic                  timeout_q;

    logic [DATA_WIDTH-1:0] exp_data;
    logic                  wr_hs, ar_hs, r_hs, any_hs, in_test, is_last, wd_expire;

    assign exp_data = DATA_WIDTH'(sdram_pattern(PAT_W'(addr_q), PAT_W'(SEED)));

    // The controller only accepts aw and w together, so both readies must coincide.
    assign wr_hs   = (state_q == ST_WRITE) && m_axi_awready && m_axi_wready;
    assign ar_hs   = (state_q == ST_READ_ADDR) && m_axi_arready;
    assign r_hs    = (state_q == ST_READ_DATA) && m_axi_rvalid;
    assign any_hs  = wr_hs || ar_hs || r_hs;
    assign in_test = (state_q == ST_WRITE) || (state_q == ST_READ_ADDR) ||
                     (state_q == ST_READ_DATA);
    assign is_last = (word_cnt_q == LAST_CNT);

    sdram_tester_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk    (clk),
        .reset  (reset),
        .clear  (any_hs || !in_test),
        .enable (in_test && !any_hs),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            word_cnt_q  <= '0;
            err_cnt_q   <= '0;
            ferr_addr_q <= '0;
            ferr_data_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_WRITE;
                        addr_q      <= START_ADDR;
                        word_cnt_q  <= '0;
                        err_cnt_q   <= '0;
                        ferr_addr_q <= '0;
                        ferr_data_q <= '0;
                        timeout_q   <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (wr_hs) begin
                        if (is_last) begin
                            state_q    <= ST_READ_ADDR;
                            addr_q     <= START_ADDR;
                            word_cnt_q <= '0;
                        end else begin
                            addr_q     <= addr_q + ADDR_WIDTH'(1);
                            word_cnt_q <= word_cnt_q + WCW'(1);
                        end
                    end else if (wd_expire) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_READ_ADDR: begin
                    if (ar_hs) begin
                        state_q <= ST_READ_DATA;
                    end else if (wd_expire) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_READ_DATA: begin
                    if (r_hs) begin
                        if (m_axi_rdata != exp_data) begin
                            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
                            if (err_cnt_q == 16'd0) begin
                                ferr_addr_q <= addr_q;
                                ferr_data_q <= m_axi_rdata;
                            end
                        end
                        if (is_last) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q    <= ST_READ_ADDR;
                            addr_q     <= addr_q + ADDR_WIDTH'(1);
                            word_cnt_q <= word_cnt_q + WCW'(1);
                        end
                    end else if (wd_expire) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Payloads are gated to zero outside their phase so idle/reset outputs are all-zero.
    assign busy           = in_test;
    assign done           = (state_q == ST_DONE);
    assign pass           = done && (err_cnt_q == 16'd0) && !timeout_q;
    assign timeout        = timeout_q;
    assign error_count    = err_cnt_q;
    assign first_err_addr = ferr_addr_q;
    assign first_err_data = ferr_data_q;
    assign m_axi_awvalid  = (state_q == ST_WRITE);
    assign m_axi_wvalid   = (state_q == ST_WRITE);
    assign m_axi_awaddr   = m_axi_awvalid ? addr_q : '0;
    assign m_axi_wdata    = m_axi_wvalid ? exp_data : '0;
    assign m_axi_arvalid  = (state_q == ST_READ_ADDR);
    assign m_axi_araddr   = m_axi_arvalid ? addr_q : '0;
    assign m_axi_rready   = (state_q == ST_READ_DATA);

endmodule

// File: tb/tb_sdram_mem_tester.sv
// Directed + randomized bench for sdram_mem_tester with a behavioural memory
// slave and a pattern/scoreboard model derived from the address rule.
module tb_sdram_mem_tester;

    localparam int          AW    = 25;
    localparam int          DW    = 16;
    localparam int          START = 'h10;
    localparam int          NW    = 4;
    localparam logic [15:0] SEED  = 16'hA5A5;
    localparam int          TMO   = 64;

    logic          clk, reset, start;
    logic          busy, done, pass, timeout;
    logic [15:0]   error_count;
    logic [AW-1:0] first_err_addr, awaddr, araddr;
    logic [DW-1:0] first_err_data, wdata, rdata;
    logic          awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;

    sdram_mem_tester #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_ADDR(AW'(START)),
        .NUM_WORDS(NW), .SEED(SEED), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .error_count(error_count), .first_err_addr(first_err_addr),
        .first_err_data(first_err_data),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave behaviour: 0 always ready, 1 random readiness, 2 arready never, 3 aw/w driven by main
    int          mode = 0;
    logic [15:0] mem [int];
    logic [15:0] bad [int];
    int          wr_a[$];
    logic [15:0] wr_d[$];
    int          rd_a[$];
    bit          pend = 0;
    int          pend_addr = 0;

    function automatic logic [15:0] ret(input int a);
        if (bad.exists(a)) return bad[a];
        if (mem.exists(a)) return mem[a];
        return 16'h0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = '0;
        forever begin
            @(posedge clk);
            if (!reset) begin
                if (awvalid && awready && wvalid && wready) begin
                    mem[int'(awaddr)] = wdata;
                    wr_a.push_back(int'(awaddr));
                    wr_d.push_back(wdata);
                end
                if (arvalid && arready) begin
                    pend = 1; pend_addr = int'(araddr); rd_a.push_back(pend_addr);
                end
                if (rvalid && rready) pend = 0;
            end
            @(negedge clk);
            if (reset) begin
                pend = 0; rvalid = 0;
            end else begin
                if (mode != 3) begin
                    awready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                    wready  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                arready = (mode == 2) ? 1'b0 : ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1);
                if (pend && !rvalid && (mode != 1 || $urandom_range(0, 1) == 1)) begin
                    rvalid = 1; rdata = ret(pend_addr);
                end else if (!pend) begin
                    rvalid = 0;
                end
            end
        end
    end

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 3000) begin @(negedge clk); n++; end
        check({tag, "_done_reached"}, 64'(done), 64'd1);
    endtask

    task automatic run(input string tag);
        wr_a.delete(); wr_d.delete(); rd_a.delete();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        wait_done(tag);
    endtask

    // Scoreboard: writes must follow the address rule, reads cover the range in
    // order, and the reported errors follow from what the slave returned.
    task automatic verify(input string tag);
        int exp_err = 0, fa = 0;
        logic [15:0] fd = '0, r;
        check({tag, "_wr_count"}, 64'(wr_a.size()), 64'(NW));
        check({tag, "_rd_count"}, 64'(rd_a.size()), 64'(NW));
        for (int i = 0; i < NW && i < wr_a.size() && i < rd_a.size(); i++) begin
            check({tag, "_wr_addr"}, 64'(wr_a[i]), 64'(START + i));
            check({tag, "_wr_data"}, 64'(wr_d[i]), 64'(16'(START + i) ^ SEED));
            check({tag, "_rd_addr"}, 64'(rd_a[i]), 64'(START + i));
        end
        for (int a = START; a < START + NW; a++) begin
            r = ret(a);
            if (r !== (16'(a) ^ SEED)) begin
                if (exp_err == 0) begin fa = a; fd = r; end
                exp_err++;
            end
        end
        check({tag, "_error_count"}, 64'(error_count), 64'(exp_err));
        check({tag, "_first_err_addr"}, 64'(first_err_addr), 64'(fa));
        check({tag, "_first_err_data"}, 64'(first_err_data), 64'(fd));
        check({tag, "_pass"}, 64'(pass), 64'(exp_err == 0));
        check({tag, "_timeout"}, 64'(timeout), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        int n;
        reset = 1; start = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_pass", 64'(pass), 0);
        check("rst_valids", 64'({awvalid, wvalid, arvalid, rready}), 0);
        check("rst_payload", 64'({awaddr, wdata, araddr}), 0);
        check("rst_errs", 64'({error_count, first_err_addr, first_err_data, timeout}), 0);
        reset = 0;

        // 1: clean memory
        mode = 0;
        run("t1");
        verify("t1");
        if (wr_d.size() == NW) begin
            check("t1_wdata0", 64'(wr_d[0]), 64'h A5B5);
            check("t1_wdata3", 64'(wr_d[3]), 64'h A5B6);
        end

        // 2: two corrupted words
        bad[16'h12] = 16'h0000; bad[16'h13] = 16'hFFFF;
        run("t2");
        verify("t2");
        check("t2_err2", 64'(error_count), 2);

        // 3+6: restart from DONE with errors clears status; partial ready stalls; start while busy ignored
        bad.delete();
        mode = 3; awready = 0; wready = 0;
        wr_a.delete(); wr_d.delete(); rd_a.delete();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        check("t3_done_clr", 64'(done), 0);
        check("t3_err_clr", 64'(error_count), 0);
        check("t3_ferr_clr", 64'({first_err_addr, first_err_data}), 0);
        check("t3_busy", 64'(busy), 1);
        awready = 1; wready = 0;
        a0 = awaddr; d0 = wdata;
        check("t3_first_addr", 64'(a0), 64'(START));
        check("t3_first_data", 64'(d0), 64'h A5B5);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            @(negedge clk);
            check("t3_stall_valids", 64'({awvalid, wvalid}), 64'b11);
            check("t3_stall_addr", 64'(awaddr), 64'(a0));
            check("t3_stall_data", 64'(wdata), 64'(d0));
        end
        start = 0;
        check("t3_no_write", 64'(wr_a.size()), 0);
        wready = 1;
        @(negedge clk);
        check("t3_one_write", 64'(wr_a.size()), 1);
        check("t3_addr_adv", 64'(awaddr), 64'(a0 + 1));
        mode = 0;
        wait_done("t3");
        verify("t3");

        // randomized readiness and corruption
        for (int r = 0; r < 4; r++) begin
            mode = 1; bad.delete();
            for (int k = 0; k < int'($urandom_range(0, 3)); k++)
                bad[START + int'($urandom_range(0, NW - 1))] = 16'($urandom);
            run("trand");
            verify("trand");
        end

        // 4: arready never rises
        mode = 2; bad.delete();
        wr_a.delete(); wr_d.delete(); rd_a.delete();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        n = 0;
        while (!arvalid && n < 200) begin @(negedge clk); n++; end
        check("t4_arvalid_seen", 64'(arvalid), 1);
        n = 0;
        while (!timeout && n < 200) begin @(negedge clk); n++; end
        check("t4_timeout_cycles", 64'(n), 64'(TMO));
        check("t4_timeout", 64'(timeout), 1);
        check("t4_arvalid_low", 64'(arvalid), 0);
        check("t4_done", 64'(done), 1);
        check("t4_pass", 64'(pass), 0);

        // 5: async reset during the read pass
        mode = 0;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        n = 0;
        while (!(arvalid && araddr == AW'(START + 2)) && n < 200) begin @(negedge clk); n++; end
        check("t5_reached_word2", 64'(araddr), 64'(START + 2));
        #2 reset = 1;
        #1;
        check("t5_rst_valids", 64'({awvalid, wvalid, arvalid, rready}), 0);
        check("t5_rst_status", 64'({busy, done, pass, timeout}), 0);
        check("t5_rst_payload", 64'({awaddr, wdata, araddr}), 0);
        @(negedge clk); reset = 0;
        run("t5");
        verify("t5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
